// File: rtl/word_pack_pkg.sv
// word_pack_pkg: shared widths and lane placement for the byte-to-word packer.
// Optional macro WORD_PACKER_LSB_FIRST_EN selects LSB-first byte placement
// (first byte in [7:0]); default is MSB-first (first byte in [WORD_W-1 -: BYTE_W]).
package word_pack_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 4;
  localparam int unsigned WORD_W    = BYTE_W * NUM_BYTES;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES);
  localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);

  // Bit offset of the least significant bit of byte lane k within a word.
  function automatic int unsigned lane_lsb(input logic [CNT_W-1:0] k);
`ifdef WORD_PACKER_LSB_FIRST_EN
    return 32'(k) * BYTE_W;
`else
    return WORD_W - (32'(k) + 32'd1) * BYTE_W;
`endif
  endfunction

endpackage

// File: rtl/word_pack_out_reg.sv
// word_pack_out_reg: one-entry valid/ready holding register for a packed word.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_load          capture i_data/i_bytes/i_last (only asserted when not stalled)
//   i_data/i_bytes/i_last  word payload to capture
//   i_ready         downstream ready
//   o_data/o_bytes/o_last/o_valid  held word
//   o_stall         holding a word the downstream is not taking this cycle
module word_pack_out_reg
  import word_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic [BCNT_W-1:0] i_bytes,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [BCNT_W-1:0] o_bytes,
  output logic              o_last,
  output logic              o_valid,
  output logic              o_stall
);

  logic [WORD_W-1:0] r_data;
  logic [BCNT_W-1:0] r_bytes;
  logic              r_last;
  logic              r_valid;

  assign o_stall = r_valid && !i_ready;

  // A load always wins: covers both the empty case and drain-plus-reload in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_bytes <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_bytes <= i_bytes;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_bytes = r_bytes;
  assign o_last  = r_last;
  assign o_valid = r_valid;

endmodule

// File: rtl/word_packer.sv
// word_packer: packs a valid/ready byte stream into WORD_W-bit words.
// in_last flushes a partial word (zero padded) and reports its byte count.
// Optional macro WORD_PACKER_LSB_FIRST_EN: first byte in the low lane instead of the high lane.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data/in_valid/in_last       byte stream input
//   in_ready                       byte accepted when in_valid && in_ready
//   out_data/out_bytes/out_last    packed word, valid byte count, packet end
//   out_valid/out_ready            word handshake
module word_packer
  import word_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [BCNT_W-1:0] out_bytes,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_stall;
  logic              w_at_top;
  logic              w_accept;
  logic              w_complete;
  logic [WORD_W-1:0] w_lane;
  logic [WORD_W-1:0] w_merged;
  logic [BCNT_W-1:0] w_bytes;

  assign w_at_top = (r_cnt == CNT_W'(NUM_BYTES - 1));

  // Only a completing byte needs the output register, so only it waits on a stall.
  assign in_ready   = !(w_stall && (w_at_top || in_last));
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (w_at_top || in_last);

  // Lanes at and beyond r_cnt are still zero, so OR-ing in the new byte is enough.
  always_comb begin
    w_lane   = WORD_W'(in_data) << lane_lsb(r_cnt);
    w_merged = r_acc | w_lane;
    w_bytes  = BCNT_W'(r_cnt) + BCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_complete) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_merged;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  word_pack_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_complete),
    .i_data  (w_merged),
    .i_bytes (w_bytes),
    .i_last  (in_last),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_bytes (out_bytes),
    .o_last  (out_last),
    .o_valid (out_valid),
    .o_stall (w_stall)
  );

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        l;
    logic        r;
    logic        rdy;
    logic        ov;
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] stream_words[4];

  // Expected words are written MSB-first; the LSB-first build is the byte reverse.
  function automatic logic [31:0] exp_word(input logic [31:0] m);
`ifdef WORD_PACKER_LSB_FIRST_EN
    return {m[7:0], m[15:8], m[23:16], m[31:24]};
`else
    return m;
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l, input logic r,
                              input logic rdy, input logic ov, input logic [31:0] data,
                              input logic [2:0] bytes, input logic last);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.r = r; t.rdy = rdy; t.ov = ov;
    t.data = data; t.bytes = bytes; t.last = last;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves time at posedge+4 for sampling.
  task automatic drive(input logic [7:0] d, input logic v, input logic l, input logic r);
    in_data = d; in_valid = v; in_last = l; out_ready = r;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [31:0] data, input logic [2:0] bytes,
                          input logic last);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".data"}, out_data, exp_word(data));
    chk({name, ".bytes"}, 32'(out_bytes), 32'(bytes));
    chk({name, ".last"}, 32'(out_last), 32'(last));
  endtask

  initial begin
    // Full word, partial flush, single-byte last.
    vecs[0]  = mk(8'h12, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[1]  = mk(8'h34, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[2]  = mk(8'h56, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[3]  = mk(8'h78, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[4]  = mk(8'h00, 0, 0, 1, 1, 1, 32'h12345678, 3'd4, 0);
    vecs[5]  = mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[6]  = mk(8'hAA, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[7]  = mk(8'hBB, 1, 1, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[8]  = mk(8'h00, 0, 0, 1, 1, 1, 32'hAABB0000, 3'd2, 1);
    vecs[9]  = mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[10] = mk(8'h9C, 1, 1, 1, 1, 0, 32'h0, 3'd0, 0);
    vecs[11] = mk(8'h00, 0, 0, 1, 1, 1, 32'h9C000000, 3'd1, 1);
    vecs[12] = mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 3'd0, 0);
    stream_words[0] = 32'h00010203;
    stream_words[1] = 32'h04050607;
    stream_words[2] = 32'h08090A0B;
    stream_words[3] = 32'h0C0D0E0F;

    // Reset state.
    rst_n = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    #3;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", out_data, 32'h0);
    chk("rst.bytes", 32'(out_bytes), 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // Table-driven basic vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].r);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      if (vecs[i].ov) chk_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].bytes, vecs[i].last);
      else chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd0);
      tick();
    end

    // Streaming 16 bytes, out_ready held high.
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 1, 0, 1);
      chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0 && (i % 4) == 0) chk_word($sformatf("stream%0d", i), stream_words[i/4 - 1], 3'd4, 0);
      else chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd0);
      tick();
    end
    drive(8'h00, 0, 0, 1);
    chk_word("stream_end", stream_words[3], 3'd4, 0);
    tick();
    drive(8'h00, 0, 0, 1);
    chk("stream_drained.valid", 32'(out_valid), 32'd0);
    tick();

    // Backpressure: hold one word, keep filling, stall on completing byte.
    drive(8'hDE, 1, 0, 0); chk("bp.fill0.in_ready", 32'(in_ready), 32'd1); tick();
    drive(8'hAD, 1, 0, 0); chk("bp.fill1.in_ready", 32'(in_ready), 32'd1); tick();
    drive(8'hBE, 1, 0, 0); chk("bp.fill2.in_ready", 32'(in_ready), 32'd1); tick();
    drive(8'hEF, 1, 0, 0); chk("bp.fill3.in_ready", 32'(in_ready), 32'd1); tick();
    drive(8'h00, 0, 1, 0);
    chk("bp.last_at_cnt0.in_ready", 32'(in_ready), 32'd0);
    chk_word("bp.held", 32'hDEADBEEF, 3'd4, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(8'(i), 1, 0, 0);
      chk($sformatf("bp.byte%0d.in_ready", i), 32'(in_ready), 32'd1);
      chk_word($sformatf("bp.hold%0d", i), 32'hDEADBEEF, 3'd4, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(8'h04, 1, 0, 0);
      chk($sformatf("bp.stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      chk_word($sformatf("bp.stall%0d", i), 32'hDEADBEEF, 3'd4, 0);
      tick();
    end
    drive(8'h04, 1, 0, 1);
    chk("bp.release.in_ready", 32'(in_ready), 32'd1);
    chk_word("bp.release", 32'hDEADBEEF, 3'd4, 0);
    tick();
    drive(8'h00, 0, 0, 1);
    chk_word("bp.next", 32'h01020304, 3'd4, 0);
    tick();
    drive(8'h00, 0, 0, 1);
    chk("bp.drained.valid", 32'(out_valid), 32'd0);
    tick();

    // Reset mid-word discards the partial word.
    drive(8'h11, 1, 0, 1); tick();
    drive(8'h22, 1, 0, 1); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("midrst.held.valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    drive(8'h33, 1, 0, 1); chk("midrst.b0.valid", 32'(out_valid), 32'd0); tick();
    drive(8'h44, 1, 0, 1); chk("midrst.b1.valid", 32'(out_valid), 32'd0); tick();
    drive(8'h55, 1, 0, 1); chk("midrst.b2.valid", 32'(out_valid), 32'd0); tick();
    drive(8'h66, 1, 0, 1); chk("midrst.b3.valid", 32'(out_valid), 32'd0); tick();
    drive(8'h00, 0, 0, 1);
    chk_word("midrst.word", 32'h33445566, 3'd4, 0);
    tick();
    drive(8'h00, 0, 0, 1);
    chk("midrst.after.valid", 32'(out_valid), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
